// File: rtl/ssd_src_arbiter.sv
// Round-robin time-sharing of the 4-digit seven-segment display between two sources,
// with a minimum dwell per source under contention and a blank gap between sources.
module ssd_src_arbiter #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLANK_CYCLES = 5_000_000,
  parameter int CNT_W        = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [15:0] number,
  output logic        blank
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_MAX = CNT_W'(BLANK_CYCLES - 1);

  state_t            r_state;
  logic [1:0]        r_gnt;
  logic [15:0]       r_number;
  logic              r_blank;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;

  state_t            w_state_nx;
  logic [1:0]        w_gnt_nx;
  logic [15:0]       w_number_nx;
  logic              w_blank_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              w_last_nx;
  logic              w_do_grant;

  logic              w_any;
  logic              w_pick;
  logic [15:0]       w_pick_data;
  logic              w_req_cur;
  logic              w_req_oth;
  logic [15:0]       w_cur_data;

  // Under contention the source that was not shown last wins; r_last is
  // also the currently granted source while in SHOW.
  assign w_any       = |req;
  assign w_pick      = (req[0] && req[1]) ? ~r_last : req[1];
  assign w_pick_data = w_pick ? data1 : data0;
  assign w_req_cur   = req[r_last];
  assign w_req_oth   = req[~r_last];
  assign w_cur_data  = r_last ? data1 : data0;

  always_comb begin
    w_state_nx  = r_state;
    w_gnt_nx    = r_gnt;
    w_number_nx = r_number;
    w_blank_nx  = r_blank;
    w_cnt_nx    = r_cnt;
    w_last_nx   = r_last;
    w_do_grant  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_gnt_nx   = 2'b00;
        w_blank_nx = 1'b1;
        w_do_grant = w_any;
      end
      S_SHOW: begin
        w_number_nx = w_cur_data;
        if (!w_req_cur) begin
          w_state_nx = w_req_oth ? S_BLANK : S_IDLE;
          w_gnt_nx   = 2'b00;
          w_blank_nx = 1'b1;
          w_cnt_nx   = '0;
        end else if (r_cnt == DWELL_MAX && w_req_oth) begin
          w_state_nx = S_BLANK;
          w_gnt_nx   = 2'b00;
          w_blank_nx = 1'b1;
          w_cnt_nx   = '0;
        end else if (r_cnt != DWELL_MAX) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_BLANK: begin
        w_gnt_nx   = 2'b00;
        w_blank_nx = 1'b1;
        if (r_cnt == BLANK_MAX) begin
          // Gap length is fixed; only the request state at its end matters.
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
          w_do_grant = w_any;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = 2'b00;
        w_blank_nx = 1'b1;
        w_cnt_nx   = '0;
      end
    endcase

    if (w_do_grant) begin
      w_state_nx  = S_SHOW;
      w_gnt_nx    = w_pick ? 2'b10 : 2'b01;
      w_last_nx   = w_pick;
      w_number_nx = w_pick_data;
      w_blank_nx  = 1'b0;
      w_cnt_nx    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= 2'b00;
      r_number <= 16'h0000;
      r_blank  <= 1'b1;
      r_cnt    <= '0;
      r_last   <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_gnt    <= w_gnt_nx;
      r_number <= w_number_nx;
      r_blank  <= w_blank_nx;
      r_cnt    <= w_cnt_nx;
      r_last   <= w_last_nx;
    end
  end

  assign gnt    = r_gnt;
  assign number = r_number;
  assign blank  = r_blank;

endmodule

// File: doc/ssd_src_arbiter.md
Name: ssd_src_arbiter

Overview:
Time-shares the 4-digit hex seven-segment display between two requesters, e.g. a debug/status source and an application value source. It sits directly upstream of the display controller and drives that controller's 16-bit number input. Round-robin arbitration applies a minimum dwell time per source and inserts a blank gap between sources, so that consecutive values are never visually merged.

Parameters:
DWELL_CYCLES, 100_000_000, minimum cycles a granted source is shown under contention (1 s at 100 MHz); must be >= 1
BLANK_CYCLES, 5_000_000, cycles the display is blanked between two different sources; must be >= 1
CNT_W, 27, width of the shared dwell/blank counter; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active low
req  input  2  req[i] high = source i wants the display (level, may drop at any time)
data0  input  16  value from source 0, 4 hex digits
data1  input  16  value from source 1, 4 hex digits
gnt  output  2  one-hot grant, registered; 2'b00 when none
number  output  16  value to display controller, registered
blank  output  1  registered; 1 = parent forces all anodes off (an = 4'b1111)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, gnt=2'b00, number=16'h0000, blank=1, cnt=0, last=1 (so source 0 wins the first contention). Reset overrides everything, including mid-SHOW or mid-BLANK.
- Arbitration function pick(): only one req high -> that source; both high -> the source != last; none -> no grant.
- IDLE: blank=1, gnt=00, number holds its value. If any req is high in cycle N, then in cycle N+1: gnt=onehot(pick), last=pick, number=data_pick, blank=0, cnt=0, state SHOW. Single-cycle latency from req to displayed value.
- SHOW (source g): number is re-registered from data_g every cycle, so live updates appear one cycle later. cnt increments each cycle, saturating at DWELL_CYCLES-1. Evaluation order each cycle:
  a) req[g] low (early release): if req[other] is high -> BLANK; else -> IDLE. Either way gnt=00, blank=1, cnt=0 next cycle.
  b) else if cnt==DWELL_CYCLES-1 and req[other] high -> BLANK (gnt=00, blank=1, cnt=0).
  c) else stay in SHOW. With no contention a source holds the display indefinitely, and cnt stays saturated.
- BLANK: gnt=00, blank=1, number holds. cnt counts 0..BLANK_CYCLES-1. At cnt==BLANK_CYCLES-1, apply pick() with current req (last still = previous source, so a waiting other source wins): a grant -> SHOW as from IDLE; no req -> IDLE. Req changes during BLANK do not shorten the gap.
- A source that arrives while the other is in SHOW waits until the dwell expires. It is served within DWELL_CYCLES+BLANK_CYCLES+1 cycles of asserting, provided it holds req.
- gnt is always one-hot or zero. blank==1 exactly when gnt==00.
- No combinational path from inputs to outputs.

Test Plan (DWELL_CYCLES=8, BLANK_CYCLES=2, CNT_W=4):
1. Hold rst_n=0 for 3 cycles with req=11 -> gnt=00, number=0000, blank=1. Release rst_n, req=11, data0=1234, data1=ABCD -> one cycle later gnt=01, number=1234, blank=0.
2. Continue test 1 with req=11 held -> source 0 shown for exactly 8 cycles, then 2 cycles of blank=1/gnt=00, then gnt=10, number=ABCD. Next 8 cycles later, 2 blank, then gnt=01 again, so the sources alternate.
3. From IDLE, req=10, data1=00FF; change data1 to 0F0F in SHOW -> number=00FF one cycle after req, 0F0F one cycle after the change. Stays granted beyond 8 cycles with req0=0.
4. Source 0 in SHOW at cnt=3, drop req0 with req1=0 -> next cycle gnt=00, blank=1, IDLE. Repeat with req1=1 -> BLANK for 2 cycles, then gnt=10.
5. In BLANK after source 0, drop req1 and keep req0=1 -> after gap gnt=01 (re-grant previous). Drop both -> IDLE with gnt=00.
6. rst_n=0 for one cycle mid-SHOW at cnt=5 -> next cycle gnt=00, number=0000, blank=1. With req=11 after release, source 0 is granted first.
